cnt_snapshot_arbiter: RTL

Shares one clock-domain-crossed counter between several consumers that need timestamp snapshots. Requests are arbitrated round-robin, and each grant returns the counter value plus its delta since the same requester's previous snapshot. The block sits in the destination clock domain, directly after the gray-code counter synchronizer. It also checks that the synchronized count never moves backwards.

---
 rtl/cnt_snapshot_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cnt_snapshot_arbiter.sv
// Round-robin timestamp snapshot arbiter behind the gray-count synchronizer.
// Returns the snapshot plus per-requester delta and flags backward count steps.
module cnt_snapshot_arbiter #(
    parameter int WIDTH = 28,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] cnt_sync,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    input  logic             clr_err,
    output logic [NREQ-1:0]  gnt,
    output logic             ts_valid,
    output logic [IDW-1:0]   ts_id,
    output logic [WIDTH-1:0] ts_data,
    output logic [WIDTH-1:0] ts_delta,
    output logic             mono_err
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   ts_id_q, ts_id_d;
    logic [WIDTH-1:0] ts_data_q, ts_data_d;
    logic [WIDTH-1:0] ts_delta_q, ts_delta_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] last_ts_q [NREQ];
    logic [WIDTH-1:0] last_ts_d [NREQ];
    logic [NREQ-1:0]  first_q, first_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             mono_err_q, mono_err_d;

    logic [NREQ-1:0]  eligible;
    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW:0]     pos;
    logic [WIDTH-1:0] step;
    logic             back_step;

    // The requester granted this cycle is masked so a held req is not re-granted.
    assign eligible = req & ~gnt_q;

    // Search eligible requesters starting at ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int j = 0; j < NREQ; j++) begin
            pos = {1'b0, ptr_q} + (IDW + 1)'(j);
            if (pos >= NREQ_W) begin
                pos = pos - NREQ_W;
            end
            if (!found && eligible[pos[IDW-1:0]]) begin
                found = 1'b1;
                win   = pos[IDW-1:0];
            end
        end
    end

    // Grant bookkeeping: register snapshot, delta, per-requester history, pointer.
    always_comb begin
        gnt_d      = '0;
        ts_id_d    = ts_id_q;
        ts_data_d  = ts_data_q;
        ts_delta_d = ts_delta_q;
        ptr_d      = ptr_q;
        last_ts_d  = last_ts_q;
        first_d    = first_q;
        if (en && found) begin
            gnt_d[win]     = 1'b1;
            ts_id_d        = win;
            ts_data_d      = cnt_sync;
            ts_delta_d     = first_q[win] ? '0 : cnt_sync - last_ts_q[win];
            last_ts_d[win] = cnt_sync;
            first_d[win]   = 1'b0;
            ptr_d          = (win == LAST_IDX) ? '0 : win + 1'b1;
        end
    end

    // Backward-step detector; the top bit of the modular step marks a regression.
    always_comb begin
        step         = cnt_sync - prev_q;
        back_step    = prev_valid_q & step[WIDTH-1];
        prev_d       = cnt_sync;
        prev_valid_d = 1'b1;
        mono_err_d   = back_step | (mono_err_q & ~clr_err);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_q        <= '0;
            ts_id_q      <= '0;
            ts_data_q    <= '0;
            ts_delta_q   <= '0;
            ptr_q        <= '0;
            first_q      <= '1;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            mono_err_q   <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                last_ts_q[i] <= '0;
            end
        end else begin
            gnt_q        <= gnt_d;
            ts_id_q      <= ts_id_d;
            ts_data_q    <= ts_data_d;
            ts_delta_q   <= ts_delta_d;
            ptr_q        <= ptr_d;
            first_q      <= first_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            mono_err_q   <= mono_err_d;
            last_ts_q    <= last_ts_d;
        end
    end

    assign gnt      = gnt_q;
    assign ts_valid = |gnt_q;
    assign ts_id    = ts_id_q;
    assign ts_data  = ts_data_q;
    assign ts_delta = ts_delta_q;
    assign mono_err = mono_err_q;

endmodule
